// File: rtl/lc3_mem_pkg.sv
// Shared definitions for the LC3 memory responder.
//   - channel FSM state encodings (constants plus a matching enum for debug views)
//   - default latencies, word width, LFSR seed
//   - lfsr_next(): one step of the 8-bit LFSR x^8+x^6+x^5+x^4+1, used only when
//     LC3_MEM_VAR_LAT_EN is defined
package lc3_mem_pkg;

    localparam int WORD_W       = 16;
    localparam int DEF_IMEM_LAT = 2;
    localparam int DEF_DMEM_LAT = 3;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_ACK     = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        BUSY    = ST_BUSY,
        ACK     = ST_ACK,
        RELEASE = ST_RELEASE
    } chan_state_e;

    // Fibonacci form, shifting left; feedback from bits 7,5,4,3
    // (exponents 8,6,5,4 of the polynomial).
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

endpackage

// File: rtl/lc3_mem_chan.sv
// One request/complete channel of the LC3 memory responder.
// FSM IDLE -> BUSY -> ACK -> (RELEASE | IDLE) with a latency down-counter.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   req_i          request qualifying acceptance (macc and, for fetch, rd)
//   hold_i         raw macc level; keeps the channel in RELEASE until it drops
//   extra_lat_i    extra cycles added to LAT at acceptance (0 when fixed latency)
//   capture_en_o   1 on the edge a request is accepted (top captures address/data)
//   ack_o          1 on the edge the access completes (top loads dout / commits write)
//   state_o        current FSM state, for observation
// Handshake: a request is a level held by the requester; it is accepted once from
// IDLE, completes with a single ack_o, and cannot be accepted again until the level
// has been seen low.
module lc3_mem_chan
    import lc3_mem_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_i,
    input  logic       hold_i,
    input  logic [1:0] extra_lat_i,
    output logic       capture_en_o,
    output logic       ack_o,
    output logic [1:0] state_o
);

    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        capture_en_o = 1'b0;
        ack_o        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    capture_en_o = 1'b1;
                    // Counter starts at LAT-1 so the ack edge lands LAT edges after acceptance.
                    cnt_d        = 8'(LAT - 1) + {6'd0, extra_lat_i};
                    state_d      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 8'd0) begin
                    ack_o   = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_ACK: begin
                state_d = hold_i ? ST_RELEASE : ST_IDLE;
            end
            ST_RELEASE: begin
                if (!hold_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/lc3_mem_responder.sv
// Memory-side responder for the LC3 fetch/data bus.
// Unified word-addressed memory (2**ADDR_W x 16) with one fetch read channel and one
// data read/write channel, each completing after a fixed latency.
// Optional feature: define LC3_MEM_VAR_LAT_EN to add 0..3 pseudo-random cycles per
// access from a shared 8-bit LFSR (fetch uses lfsr[1:0], data uses lfsr[3:2]).
// Ports:
//   clock, reset                  clock, synchronous active-high reset
//   pc, instrmem_rd, I_macc       fetch request (accepted only with instrmem_rd=1)
//   Data_addr, Data_din, Data_rd, D_macc   data request (Data_rd=0 is a write)
//   Instr_dout, complete_instr    fetch result and one-cycle completion pulse
//   Data_dout, complete_data      read result and one-cycle completion pulse
//   dbg_i_state_o, dbg_d_state_o  channel FSM states for observation
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int IMEM_LAT = DEF_IMEM_LAT,
    parameter int DMEM_LAT = DEF_DMEM_LAT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WORD_W-1:0] pc,
    input  logic              instrmem_rd,
    input  logic              I_macc,
    input  logic [WORD_W-1:0] Data_addr,
    input  logic [WORD_W-1:0] Data_din,
    input  logic              Data_rd,
    input  logic              D_macc,
    output logic [WORD_W-1:0] Instr_dout,
    output logic [WORD_W-1:0] Data_dout,
    output logic              complete_instr,
    output logic              complete_data,
    output logic [1:0]        dbg_i_state_o,
    output logic [1:0]        dbg_d_state_o
);

    logic [WORD_W-1:0] mem_q [2**ADDR_W];

    logic [ADDR_W-1:0] i_addr_q;
    logic [ADDR_W-1:0] d_addr_q;
    logic [WORD_W-1:0] d_din_q;
    logic              d_rd_q;
    logic [WORD_W-1:0] instr_dout_q;
    logic [WORD_W-1:0] data_dout_q;
    logic              complete_instr_q;
    logic              complete_data_q;

    logic       i_cap, i_ack, d_cap, d_ack;
    logic [1:0] i_extra, d_extra;

    // High address bits alias onto the same words.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{pc[WORD_W-1:ADDR_W], Data_addr[WORD_W-1:ADDR_W]};

`ifdef LC3_MEM_VAR_LAT_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign i_extra = lfsr_q[1:0];
    assign d_extra = lfsr_q[3:2];
`else
    assign i_extra = 2'd0;
    assign d_extra = 2'd0;
`endif

    lc3_mem_chan #(.LAT(IMEM_LAT)) u_ichan (
        .clk_i        (clock),
        .rst_i        (reset),
        .req_i        (I_macc & instrmem_rd),
        .hold_i       (I_macc),
        .extra_lat_i  (i_extra),
        .capture_en_o (i_cap),
        .ack_o        (i_ack),
        .state_o      (dbg_i_state_o)
    );

    lc3_mem_chan #(.LAT(DMEM_LAT)) u_dchan (
        .clk_i        (clock),
        .rst_i        (reset),
        .req_i        (D_macc),
        .hold_i       (D_macc),
        .extra_lat_i  (d_extra),
        .capture_en_o (d_cap),
        .ack_o        (d_ack),
        .state_o      (dbg_d_state_o)
    );

    // Memory contents survive reset; a write commits only on its ack edge, so a
    // reset that lands before then drops the write.
    always_ff @(posedge clock) begin
        if (!reset && d_ack && !d_rd_q) begin
            mem_q[d_addr_q] <= d_din_q;
        end
    end

    // Reads sample mem_q before any same-edge write, so a fetch completing together
    // with a write to the same word returns the old value.
    always_ff @(posedge clock) begin
        if (reset) begin
            i_addr_q         <= '0;
            d_addr_q         <= '0;
            d_din_q          <= '0;
            d_rd_q           <= 1'b0;
            instr_dout_q     <= '0;
            data_dout_q      <= '0;
            complete_instr_q <= 1'b0;
            complete_data_q  <= 1'b0;
        end else begin
            if (i_cap) begin
                i_addr_q <= pc[ADDR_W-1:0];
            end
            if (d_cap) begin
                d_addr_q <= Data_addr[ADDR_W-1:0];
                d_din_q  <= Data_din;
                d_rd_q   <= Data_rd;
            end
            complete_instr_q <= i_ack;
            complete_data_q  <= d_ack;
            if (i_ack) begin
                instr_dout_q <= mem_q[i_addr_q];
            end
            if (d_ack && d_rd_q) begin
                data_dout_q <= mem_q[d_addr_q];
            end
        end
    end

    assign Instr_dout     = instr_dout_q;
    assign Data_dout      = data_dout_q;
    assign complete_instr = complete_instr_q;
    assign complete_data  = complete_data_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
module tb_lc3_mem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pc = '0;
  logic        instrmem_rd = 1'b0;
  logic        I_macc = 1'b0;
  logic [15:0] Data_addr = '0;
  logic [15:0] Data_din = '0;
  logic        Data_rd = 1'b0;
  logic        D_macc = 1'b0;
  logic [15:0] Instr_dout;
  logic [15:0] Data_dout;
  logic        complete_instr;
  logic        complete_data;
  logic [1:0]  dbg_i_state;
  logic [1:0]  dbg_d_state;

  int n_checks = 0;
  int n_err = 0;

  lc3_mem_responder dut (
    .clock          (clock),
    .reset          (reset),
    .pc             (pc),
    .instrmem_rd    (instrmem_rd),
    .I_macc         (I_macc),
    .Data_addr      (Data_addr),
    .Data_din       (Data_din),
    .Data_rd        (Data_rd),
    .D_macc         (D_macc),
    .Instr_dout     (Instr_dout),
    .Data_dout      (Data_dout),
    .complete_instr (complete_instr),
    .complete_data  (complete_data),
    .dbg_i_state_o  (dbg_i_state),
    .dbg_d_state_o  (dbg_d_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled just after the falling edge.
  task automatic step();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: one data access, completion expected on the 3rd edge after acceptance
  task automatic data_access(input logic [15:0] addr, input logic [15:0] din,
                             input logic rd, input logic [15:0] exp_dout, input string tag);
    Data_addr = addr;
    Data_din  = din;
    Data_rd   = rd;
    D_macc    = 1'b1;
    step();
    check({tag, "_cd_e0"}, {15'd0, complete_data}, 16'd0);
    step();
    check({tag, "_cd_e1"}, {15'd0, complete_data}, 16'd0);
    step();
    check({tag, "_cd_e2"}, {15'd0, complete_data}, 16'd0);
    step();
    check({tag, "_cd_e3"}, {15'd0, complete_data}, 16'd1);
    check({tag, "_dout"}, Data_dout, exp_dout);
    D_macc = 1'b0;
    step();
    check({tag, "_cd_after"}, {15'd0, complete_data}, 16'd0);
  endtask

  // driver: one fetch, completion expected on the 2nd edge after acceptance
  task automatic fetch(input logic [15:0] addr, input logic [15:0] exp_instr, input string tag);
    pc          = addr;
    instrmem_rd = 1'b1;
    I_macc      = 1'b1;
    step();
    check({tag, "_ci_e0"}, {15'd0, complete_instr}, 16'd0);
    step();
    check({tag, "_ci_e1"}, {15'd0, complete_instr}, 16'd0);
    step();
    check({tag, "_ci_e2"}, {15'd0, complete_instr}, 16'd1);
    check({tag, "_instr"}, Instr_dout, exp_instr);
    I_macc      = 1'b0;
    instrmem_rd = 1'b0;
    step();
    check({tag, "_ci_after"}, {15'd0, complete_instr}, 16'd0);
  endtask

`ifdef LC3_MEM_VAR_LAT_EN
  logic [7:0] m_lfsr;
  always @(posedge clock) begin
    if (reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end
`endif

  initial begin
    int pulses;
    // reset
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("rst_instr_dout", Instr_dout, 16'h0000);
    check("rst_data_dout", Data_dout, 16'h0000);
    check("rst_ci", {15'd0, complete_instr}, 16'd0);
    check("rst_cd", {15'd0, complete_data}, 16'd0);
    check("rst_i_state", {14'd0, dbg_i_state}, 16'd0);
    check("rst_d_state", {14'd0, dbg_d_state}, 16'd0);

`ifndef LC3_MEM_VAR_LAT_EN
    // preload via writes (Data_dout stays 0 across writes)
    data_access(16'h0010, 16'h1234, 1'b0, 16'h0000, "wr010");
    data_access(16'h0005, 16'hAAAA, 1'b0, 16'h0000, "wr005");
    data_access(16'h0006, 16'h5555, 1'b0, 16'h0000, "wr006");
    data_access(16'h0020, 16'hBEEF, 1'b0, 16'h0000, "wr020");
    data_access(16'h0020, 16'h0000, 1'b1, 16'hBEEF, "rd020");
    data_access(16'h0420, 16'h0000, 1'b1, 16'hBEEF, "rd420_alias");
    data_access(16'h0040, 16'h1111, 1'b0, 16'hBEEF, "wr040");
    data_access(16'h0030, 16'h3030, 1'b0, 16'hBEEF, "wr030");

    fetch(16'h0010, 16'h1234, "f010");
    fetch(16'hFC10, 16'h1234, "f_alias");

    // concurrent fetch 0x0005 and data read 0x0006
    pc = 16'h0005; instrmem_rd = 1'b1; I_macc = 1'b1;
    Data_addr = 16'h0006; Data_rd = 1'b1; D_macc = 1'b1;
    step();
    step();
    check("cc_ci_e1", {15'd0, complete_instr}, 16'd0);
    step();
    check("cc_ci_e2", {15'd0, complete_instr}, 16'd1);
    check("cc_cd_e2", {15'd0, complete_data}, 16'd0);
    check("cc_instr", Instr_dout, 16'hAAAA);
    I_macc = 1'b0;
    step();
    check("cc_ci_e3", {15'd0, complete_instr}, 16'd0);
    check("cc_cd_e3", {15'd0, complete_data}, 16'd1);
    check("cc_data", Data_dout, 16'h5555);
    D_macc = 1'b0;
    step();

    // held I_macc: one pulse only; pc change after acceptance ignored
    pc = 16'h0010; instrmem_rd = 1'b1; I_macc = 1'b1;
    step();
    pc = 16'h0005;
    step();
    step();
    check("held_ci", {15'd0, complete_instr}, 16'd1);
    check("held_instr", Instr_dout, 16'h1234);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (complete_instr) pulses++;
    end
    check("held_extra_pulses", 16'(pulses), 16'd0);
    check("held_state_release", {14'd0, dbg_i_state}, 16'd3);
    I_macc = 1'b0; instrmem_rd = 1'b0;
    step();
    check("held_state_idle", {14'd0, dbg_i_state}, 16'd0);

    // I_macc without instrmem_rd is ignored
    pc = 16'h0005; I_macc = 1'b1; instrmem_rd = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (complete_instr) pulses++;
    end
    check("nord_pulses", 16'(pulses), 16'd0);
    check("nord_state", {14'd0, dbg_i_state}, 16'd0);
    I_macc = 1'b0;
    step();

    // write 0x0040 and fetch 0x0040 completing on the same edge
    Data_addr = 16'h0040; Data_din = 16'h2222; Data_rd = 1'b0; D_macc = 1'b1;
    step();
    pc = 16'h0040; instrmem_rd = 1'b1; I_macc = 1'b1;
    step();
    step();
    step();
    check("same_ci", {15'd0, complete_instr}, 16'd1);
    check("same_cd", {15'd0, complete_data}, 16'd1);
    check("same_instr_old", Instr_dout, 16'h1111);
    check("same_ddout_kept", Data_dout, 16'h5555);
    I_macc = 1'b0; instrmem_rd = 1'b0; D_macc = 1'b0;
    step();
    data_access(16'h0040, 16'h0000, 1'b1, 16'h2222, "rd040_new");
    fetch(16'h0040, 16'h2222, "f040_new");

    // reset while the write is BUSY
    Data_addr = 16'h0030; Data_din = 16'hDEAD; Data_rd = 1'b0; D_macc = 1'b1;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; D_macc = 1'b0;
    check("rb_instr_dout", Instr_dout, 16'h0000);
    check("rb_data_dout", Data_dout, 16'h0000);
    check("rb_d_state", {14'd0, dbg_d_state}, 16'd0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (complete_data) pulses++;
      step();
    end
    check("rb_no_pulse", 16'(pulses), 16'd0);
    data_access(16'h0030, 16'h0000, 1'b1, 16'h3030, "rd030_kept");
`else
    // variable latency: latency = 2 + lfsr[1:0] sampled at acceptance
    for (int n = 0; n < 40; n++) begin
      logic [1:0] extra;
      int lat;
      extra = m_lfsr[1:0];
      pc = 16'(n); instrmem_rd = 1'b1; I_macc = 1'b1;
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
        step();
        if (complete_instr && lat == 0) lat = k - 1;
      end
      check("vl_latency", 16'(lat), 16'(2 + extra));
      I_macc = 1'b0; instrmem_rd = 1'b0;
      step();
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
